// File: rtl/parity_stream_gen_pkg.sv
// Shared parity definitions for the parity stream datapath.
// Contents:
//   par_mode_e  - parity mode (PAR_EVEN / PAR_ODD)
//   PAR_MAX_W   - widest word the parity helper accepts
//   word_parity - reduction XOR of a zero-extended word, adjusted for mode
package parity_pkg;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_mode_e;

  localparam int unsigned PAR_MAX_W = 256;

  // Zero extension does not change the XOR, so callers widen to PAR_MAX_W.
  function automatic logic word_parity(input logic [PAR_MAX_W-1:0] data,
                                       input par_mode_e             mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/parity_stream_gen_if.sv
// Valid/ready stream bundle for parity_stream_gen.
// Input side : in_valid, in_ready, in_data[WIDTH], in_par
// Output side: out_valid, out_ready, out_data[WIDTH+1] ({gen_par, data}),
//              out_par_err, out_last, out_frame_par[WIDTH]
// master = word source / downstream sink, slave = parity_stream_gen.
interface parity_stream_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_par;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_data;
  logic             out_par_err;
  logic             out_last;
  logic [WIDTH-1:0] out_frame_par;

  modport master (
    output in_valid, in_data, in_par, out_ready,
    input  in_ready, out_valid, out_data, out_par_err, out_last, out_frame_par
  );

  modport slave (
    input  in_valid, in_data, in_par, out_ready,
    output in_ready, out_valid, out_data, out_par_err, out_last, out_frame_par
  );
endinterface

// File: rtl/parity_stream_gen_word.sv
// parity_word: combinational parity generator/checker for one word.
// Ports:
//   data_i     - word to protect
//   mode_i     - even/odd parity mode
//   par_i      - received parity bit to check
//   gen_par_o  - generated parity bit
//   mismatch_o - par_i differs from gen_par_o
module parity_word
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  par_mode_e        mode_i,
  input  logic             par_i,
  output logic             gen_par_o,
  output logic             mismatch_o
);

  always_comb begin
    gen_par_o  = word_parity(PAR_MAX_W'(data_i), mode_i);
    mismatch_o = par_i ^ gen_par_o;
  end

endmodule

// File: rtl/parity_stream_gen.sv
// parity_stream_gen: streaming parity generator/checker with frame
// (column) parity and a saturating mismatch counter.
// Ports:
//   clk, nrst  - clock (rising edge), asynchronous active-low reset
//   odd_mode   - parity mode, sampled on the first word of each frame
//   clr_err    - synchronous clear of err_count (wins over increment)
//   bus        - stream bundle (slave side), one output register stage
//   err_count  - saturating count of parity mismatches
module parity_stream_gen
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 odd_mode,
  input  logic                 clr_err,
  parity_stream_gen_if.slave   bus,
  output logic [CNT_W-1:0]     err_count
);

  localparam int unsigned      IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  par_mode_e        mode_q, mode_d;
  logic             ov_q, ov_d;
  logic [WIDTH:0]   od_q, od_d;
  logic             perr_q, perr_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] fp_q, fp_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic             in_ready;
  logic             accept;
  par_mode_e        mode_use;
  logic             gen_par;
  logic             mismatch;
  logic [WIDTH-1:0] acc_next;

  // Mode is sampled only at frame start; later words reuse the latched mode.
  assign mode_use = (idx_q == '0) ? par_mode_e'(odd_mode) : mode_q;

  parity_word #(.WIDTH(WIDTH)) u_word (
    .data_i     (bus.in_data),
    .mode_i     (mode_use),
    .par_i      (bus.in_par),
    .gen_par_o  (gen_par),
    .mismatch_o (mismatch)
  );

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx_q  <= '0;
      acc_q  <= '0;
      mode_q <= PAR_EVEN;
      ov_q   <= 1'b0;
      od_q   <= '0;
      perr_q <= 1'b0;
      last_q <= 1'b0;
      fp_q   <= '0;
      err_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      mode_q <= mode_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      perr_q <= perr_d;
      last_q <= last_d;
      fp_q   <= fp_d;
      err_q  <= err_d;
    end
  end

  // Next-state logic: word index FSM, accumulator, output register, counter
  always_comb begin
    idx_d    = idx_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    ov_d     = ov_q;
    od_d     = od_q;
    perr_d   = perr_q;
    last_d   = last_q;
    fp_d     = fp_q;
    err_d    = err_q;
    acc_next = acc_q ^ bus.in_data;

    if (accept) begin
      // A simultaneous transfer is covered: the new word simply replaces it.
      ov_d   = 1'b1;
      od_d   = {gen_par, bus.in_data};
      perr_d = mismatch;
      mode_d = mode_use;
      if (idx_q == LAST_IDX) begin
        last_d = 1'b1;
        fp_d   = acc_next;
        acc_d  = '0;
        idx_d  = '0;
      end else begin
        last_d = 1'b0;
        fp_d   = '0;
        acc_d  = acc_next;
        idx_d  = idx_q + IDX_W'(1);
      end
    end else if (ov_q && bus.out_ready) begin
      ov_d = 1'b0;
    end

    if (clr_err) begin
      err_d = '0;
    end else if (accept && mismatch && (err_q != '1)) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  // Outputs
  always_comb begin
    in_ready          = !ov_q || bus.out_ready;
    accept            = bus.in_valid && in_ready;
    bus.in_ready      = in_ready;
    bus.out_valid     = ov_q;
    bus.out_data      = od_q;
    bus.out_par_err   = perr_q;
    bus.out_last      = last_q;
    bus.out_frame_par = fp_q;
    err_count         = err_q;
  end

endmodule

// File: tb/tb_parity_stream_gen.sv
module tb_parity_stream_gen;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic odd_mode = 1'b0;
  logic clr_err = 1'b0;
  logic [7:0] err_count;
  logic odd1 = 1'b0;
  logic clr1 = 1'b0;
  logic [1:0] err1;

  parity_stream_gen_if #(.WIDTH(8)) bus ();
  parity_stream_gen_if #(.WIDTH(8)) bus1 ();

  parity_stream_gen #(.WIDTH(8), .FRAME_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .nrst(nrst), .odd_mode(odd_mode), .clr_err(clr_err),
    .bus(bus.slave), .err_count(err_count)
  );

  parity_stream_gen #(.WIDTH(8), .FRAME_LEN(1), .CNT_W(2)) dut1 (
    .clk(clk), .nrst(nrst), .odd_mode(odd1), .clr_err(clr1),
    .bus(bus1.slave), .err_count(err1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       last;
    logic [7:0] fp;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;

  // reference model state
  int         m_idx = 0;
  logic [7:0] m_acc = '0;
  logic       m_mode = 1'b0;
  int         m_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one word, wait (bounded) for acceptance, push its expectation.
  task automatic send(input logic [7:0] d, input logic flip, input logic odd,
                      input logic clr = 1'b0);
    logic md, gp;
    bit   ok;
    exp_t e;
    ok = 1'b0;
    md = (m_idx == 0) ? odd : m_mode;
    gp = (^d) ^ md;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_par   = gp ^ flip;
    odd_mode     = odd;
    clr_err      = clr;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_wait", 64'(ok), 64'(1));
    if (ok) begin
      m_mode  = md;
      m_acc   = m_acc ^ d;
      e.data  = {gp, d};
      e.perr  = flip;
      if (m_idx == 3) begin
        e.last = 1'b1;
        e.fp   = m_acc;
        m_acc  = '0;
        m_idx  = 0;
      end else begin
        e.last = 1'b0;
        e.fp   = '0;
        m_idx  = m_idx + 1;
      end
      if (clr) m_err = 0;
      else if (flip && m_err < 255) m_err = m_err + 1;
      q.push_back(e);
      last_exp = e;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    clr_err      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every transferred word with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (nrst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 64'(q.size()), 64'(1));
      end else begin
        e = q.pop_front();
        chk("sb_data", 64'(bus.out_data), 64'(e.data));
        chk("sb_par_err", 64'(bus.out_par_err), 64'(e.perr));
        chk("sb_last", 64'(bus.out_last), 64'(e.last));
        chk("sb_frame_par", 64'(bus.out_frame_par), 64'(e.fp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [7:0] d1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_par    = 1'b0;
    bus.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.in_par    = 1'b0;
    bus1.out_ready = 1'b1;

    // reset state
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_err_count", 64'(err_count), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    nrst = 1'b1;
    idle(2);

    // frame 1: even parity on 0x07, one cycle latency
    send(8'h07, 1'b0, 1'b0);
    chk("even07_valid", 64'(bus.out_valid), 64'(1));
    chk("even07_data", 64'(bus.out_data), 64'h107);
    chk("even07_perr", 64'(bus.out_par_err), 64'(0));
    send(8'h10, 1'b0, 1'b0);
    send(8'h20, 1'b0, 1'b0);
    send(8'h30, 1'b0, 1'b0);

    // frame 2: odd parity on 0x07
    send(8'h07, 1'b0, 1'b1);
    chk("odd07_data", 64'(bus.out_data), 64'h007);
    send(8'hA5, 1'b0, 1'b1);
    send(8'h3C, 1'b0, 1'b1);
    send(8'h81, 1'b0, 1'b1);

    // frame 3: column parity of 01,02,04,08
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0);
    chk("f3_not_last", 64'(bus.out_last), 64'(0));
    send(8'h08, 1'b0, 1'b0);
    chk("f3_last", 64'(bus.out_last), 64'(1));
    chk("f3_frame_par", 64'(bus.out_frame_par), 64'h0F);

    // frame 4: FF x4
    repeat (4) send(8'hFF, 1'b0, 1'b0);
    chk("f4_frame_par", 64'(bus.out_frame_par), 64'h00);

    // frame 5: backpressure
    idle(2);
    bus.out_ready = 1'b0;
    send(8'h5A, 1'b0, 1'b0);
    d1 = 8'hC3;
    bus.in_valid = 1'b1;
    bus.in_data  = d1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
      chk("bp_hold_data", 64'(bus.out_data), 64'(last_exp.data));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(d1, 1'b0, 1'b0);
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);

    // frame 6: back-to-back at one word per cycle
    c0 = cyc;
    send(8'h01, 1'b0, 1'b0);
    send(8'h23, 1'b0, 1'b0);
    send(8'h45, 1'b0, 1'b0);
    send(8'h67, 1'b0, 1'b0);
    chk("throughput_cycles", 64'(cyc - c0), 64'(4));

    // frame 7: three parity errors
    send(8'h12, 1'b1, 1'b0);
    send(8'h34, 1'b1, 1'b0);
    send(8'h56, 1'b1, 1'b0);
    send(8'h78, 1'b0, 1'b0);
    chk("err_count_3", 64'(err_count), 64'(3));

    // frame 8: clear wins over a simultaneous error
    send(8'h9A, 1'b1, 1'b0, 1'b1);
    chk("err_clr_wins", 64'(err_count), 64'(0));
    send(8'hBC, 1'b0, 1'b0);
    send(8'hDE, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);

    // frame 9/10: mode toggled mid-frame applies from the next frame
    send(8'h03, 1'b0, 1'b0);
    send(8'h05, 1'b0, 1'b1);
    chk("mode_mid_even", 64'(bus.out_data), 64'h005);
    send(8'h06, 1'b0, 1'b1);
    send(8'h09, 1'b0, 1'b1);
    send(8'h03, 1'b0, 1'b1);
    chk("mode_next_odd", 64'(bus.out_data), 64'h103);
    send(8'h0E, 1'b0, 1'b1);
    send(8'h70, 1'b0, 1'b1);
    send(8'h01, 1'b0, 1'b1);

    // mid-frame asynchronous reset
    send(8'hAA, 1'b1, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    chk("pre_rst_err", 64'(err_count), 64'(m_err));
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("arst_out_data", 64'(bus.out_data), 64'(0));
    chk("arst_out_last", 64'(bus.out_last), 64'(0));
    chk("arst_frame_par", 64'(bus.out_frame_par), 64'(0));
    chk("arst_par_err", 64'(bus.out_par_err), 64'(0));
    chk("arst_err_count", 64'(err_count), 64'(0));
    q.delete();
    m_idx = 0; m_acc = '0; m_mode = 1'b0; m_err = 0;
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h44, 1'b0, 1'b0);
    send(8'h80, 1'b0, 1'b0);
    chk("post_rst_last", 64'(bus.out_last), 64'(1));
    chk("post_rst_frame_par", 64'(bus.out_frame_par), 64'hF7);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("sb_drained", 64'(q.size()), 64'(0));

    // FRAME_LEN=1, CNT_W=2 instance: every word is last, counter saturates
    for (int i = 0; i < 5; i++) begin
      bus1.in_valid = 1'b1;
      bus1.in_data  = 8'(8'h30 + i);
      bus1.in_par   = ~(^bus1.in_data);
      @(posedge clk);
      #1;
      chk("f1_last", 64'(bus1.out_last), 64'(1));
      chk("f1_frame_par", 64'(bus1.out_frame_par), 64'(8'h30 + i));
      chk("f1_err_sat", 64'(err1), 64'((i + 1 > 3) ? 3 : i + 1));
    end
    bus1.in_valid = 1'b0;
    idle(1);
    chk("f1_err_hold", 64'(err1), 64'(3));
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'h01;
    bus1.in_par   = 1'b0;
    clr1 = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    clr1 = 1'b0;
    chk("f1_clr_wins", 64'(err1), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
